// File: rtl/relogio_xadrez_n_pkg.sv
// Shared definitions for the N-player chess clock: FSM encoding, seconds field, index width helper.
// Pure declarations; no latency, no backpressure.
package relogio_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRONTO   = 2'd1,
        CONTANDO = 2'd2,
        FIM      = 2'd3
    } estado_t;

    localparam int SEG_W   = 6;
    localparam int SEG_MAX = 59;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/relogio_xadrez_n_if.sv
// Control/readout bundle of the chess clock; master drives controls, slave (the clock) drives readout.
// Plain wires; no latency, no backpressure.
interface relogio_if
    import relogio_pkg::*;
#(
    parameter int N_JOG = 2,
    parameter int MIN_W = 7,
    parameter int INC_W = 6,
    parameter int IDX_W = clog2_min1(N_JOG)
);
    logic             carga;
    logic [MIN_W-1:0] chaves;
    logic             modo;
    logic [INC_W-1:0] incremento;
    logic [N_JOG-1:0] jogada;
    logic [IDX_W-1:0] sel_jog;
    logic [MIN_W-1:0] leitura_min;
    logic [SEG_W-1:0] leitura_seg;
    logic [N_JOG-1:0] vez;
    logic             fim;
    logic [IDX_W-1:0] perdedor;
    logic [1:0]       estado;

    modport master (
        output carga, chaves, modo, incremento, jogada, sel_jog,
        input  leitura_min, leitura_seg, vez, fim, perdedor, estado
    );

    modport slave (
        input  carga, chaves, modo, incremento, jogada, sel_jog,
        output leitura_min, leitura_seg, vez, fim, perdedor, estado
    );
endinterface

// File: rtl/relogio_xadrez_n_gerador_tick.sv
// One-second prescaler: tick pulses combinationally while count == CLOCK_FREQ-1 and en=1.
// Latency 0 from count to tick; clr wins over counting; no backpressure.
module gerador_tick #(
    parameter int CLOCK_FREQ = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [CW-1:0] TOPO = CW'(CLOCK_FREQ - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TOPO);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TOPO) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/relogio_xadrez_n.sv
// N-player chess clock with Fischer increment; flags the first player to reach 0:00.
// State updates one cycle after tick/press; readout is combinational; no backpressure.
module relogio_xadrez_n
    import relogio_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int N_JOG      = 2,
    parameter int MIN_W      = 7,
    parameter int INC_W      = 6,
    parameter int IDX_W      = clog2_min1(N_JOG)
) (
    input  logic clock,
    input  logic reset,
    relogio_if.slave bus
);
    localparam int T_W = MIN_W + SEG_W;
    localparam logic [MIN_W-1:0] MIN_MAX = '1;
    localparam logic [SEG_W:0]   SEG_LIM = (SEG_W + 1)'(SEG_MAX + 1);

    estado_t          estado, estado_nxt;
    logic [IDX_W-1:0] ativo, ativo_nxt, perdedor, perdedor_nxt, pri_idx;
    logic             fim, fim_nxt;
    logic [N_JOG-1:0] jogada_d, press;
    logic [T_W-1:0]   tempo     [N_JOG];
    logic [T_W-1:0]   tempo_nxt [N_JOG];
    logic [T_W-1:0]   tempo_at, t_novo, leit;
    logic             press_valida, bandeira, tick, clr;
    logic [SEG_W-1:0] inc_sat;

    function automatic logic [T_W-1:0] decrementa(input logic [T_W-1:0] t);
        logic [MIN_W-1:0] m;
        logic [SEG_W-1:0] s;
        {m, s} = t;
        if (s != '0) begin
            s = s - 1'b1;
        end else if (m != '0) begin
            m = m - 1'b1;
            s = SEG_W'(SEG_MAX);
        end
        return {m, s};
    endfunction

    // Minutes saturate at all-ones:59 rather than wrapping.
    function automatic logic [T_W-1:0] soma_inc(input logic [T_W-1:0] t, input logic [SEG_W-1:0] inc);
        logic [MIN_W-1:0] m;
        logic [SEG_W:0]   s;
        m = t[T_W-1:SEG_W];
        s = {1'b0, t[SEG_W-1:0]} + {1'b0, inc};
        if (s >= SEG_LIM) begin
            if (m == MIN_MAX) return {MIN_MAX, SEG_W'(SEG_MAX)};
            return {m + 1'b1, SEG_W'(s - SEG_LIM)};
        end
        return {m, s[SEG_W-1:0]};
    endfunction

    function automatic logic [IDX_W-1:0] proximo(input logic [IDX_W-1:0] a);
        return (a == IDX_W'(N_JOG - 1)) ? '0 : a + 1'b1;
    endfunction

    gerador_tick #(.CLOCK_FREQ(CLOCK_FREQ)) u_tick (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .en    (estado == CONTANDO),
        .tick  (tick)
    );

    assign press   = bus.jogada & ~jogada_d;
    assign inc_sat = (32'(bus.incremento) > SEG_MAX) ? SEG_W'(SEG_MAX) : SEG_W'(bus.incremento);

    always_comb begin
        tempo_at     = '0;
        press_valida = 1'b0;
        pri_idx      = '0;
        for (int i = N_JOG - 1; i >= 0; i--) begin
            if (press[i]) pri_idx = IDX_W'(i);
        end
        for (int i = 0; i < N_JOG; i++) begin
            if (ativo == IDX_W'(i)) begin
                tempo_at     = tempo[i];
                press_valida = press[i];
            end
        end
    end

    always_comb begin
        estado_nxt   = estado;
        ativo_nxt    = ativo;
        fim_nxt      = fim;
        perdedor_nxt = perdedor;
        tempo_nxt    = tempo;
        clr          = 1'b0;
        bandeira     = 1'b0;
        t_novo       = tempo_at;
        if (bus.carga) begin
            for (int i = 0; i < N_JOG; i++) tempo_nxt[i] = {bus.chaves, SEG_W'(0)};
            fim_nxt    = 1'b0;
            clr        = 1'b1;
            estado_nxt = PRONTO;
        end else begin
            case (estado)
                PRONTO: begin
                    if (|press) begin
                        ativo_nxt  = proximo(pri_idx);
                        clr        = 1'b1;
                        estado_nxt = CONTANDO;
                    end
                end
                CONTANDO: begin
                    // Decrement of the outgoing player lands before any increment.
                    if (tick) begin
                        bandeira = (tempo_at <= T_W'(1));
                        t_novo   = decrementa(tempo_at);
                    end
                    if (bandeira) begin
                        estado_nxt   = FIM;
                        fim_nxt      = 1'b1;
                        perdedor_nxt = ativo;
                    end else if (press_valida) begin
                        if (bus.modo) t_novo = soma_inc(t_novo, inc_sat);
                        ativo_nxt = proximo(ativo);
                        clr       = 1'b1;
                    end
                    for (int i = 0; i < N_JOG; i++) begin
                        if (ativo == IDX_W'(i)) tempo_nxt[i] = t_novo;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= IDLE;
            ativo    <= '0;
            fim      <= 1'b0;
            perdedor <= '0;
            jogada_d <= '0;
            for (int i = 0; i < N_JOG; i++) tempo[i] <= '0;
        end else begin
            estado   <= estado_nxt;
            ativo    <= ativo_nxt;
            fim      <= fim_nxt;
            perdedor <= perdedor_nxt;
            jogada_d <= bus.jogada;
            for (int i = 0; i < N_JOG; i++) tempo[i] <= tempo_nxt[i];
        end
    end

    always_comb begin
        leit = '0;
        for (int i = 0; i < N_JOG; i++) begin
            if (bus.sel_jog == IDX_W'(i)) leit = tempo[i];
        end
    end

    assign bus.leitura_min = leit[T_W-1:SEG_W];
    assign bus.leitura_seg = leit[SEG_W-1:0];
    assign bus.vez         = (estado == CONTANDO) ? (N_JOG'(1) << ativo) : '0;
    assign bus.fim         = fim;
    assign bus.perdedor    = perdedor;
    assign bus.estado      = estado;
endmodule

// File: doc/relogio_xadrez_n.md
Name: relogio_xadrez_n

Overview:
- N-player chess clock with Fischer increment.
- Each player owns a minutes:seconds countdown register. A valid press by the active player hands the turn to the next player in round-robin order.
- The block flags the first player whose time reaches 0:00.
- It produces binary time values only. The 7-segment multiplexer (an/dec_ddp) is a separate downstream block that selects the player through sel_jog.

Parameters:
- CLOCK_FREQ, 100_000_000, clock cycles per one-second tick.
- N_JOG, 2, number of players (2..8).
- MIN_W, 7, minutes field width; also the width of chaves.
- INC_W, 6, increment input width, in seconds.
- IDX_W, $clog2(N_JOG) (minimum 1), player index width.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous active-low reset.
- carga, input, 1: level; loads chaves minutes into every player.
- chaves, input, MIN_W: initial minutes.
- modo, input, 1: 0 = sudden death, 1 = Fischer increment.
- incremento, input, INC_W: increment in seconds; values above 59 are clamped to 59.
- jogada, input, N_JOG: per-player buttons. Already synchronised and debounced; the block detects rising edges.
- sel_jog, input, IDX_W: player selected for readout.
- leitura_min, output, MIN_W: minutes of player sel_jog.
- leitura_seg, output, 6: seconds of player sel_jog (0..59).
- vez, output, N_JOG: one-hot active player; all zeros unless in CONTANDO.
- fim, output, 1: a flag has fallen.
- perdedor, output, IDX_W: index of the flagged player; valid while fim=1.
- estado, output, 2: IDLE=0, PRONTO=1, CONTANDO=2, FIM=3.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - all player times to 0:00;
  - the prescaler and edge-detect registers;
  - vez, fim, perdedor and ativo to 0;
  - estado to IDLE.
- Edge detection: press[i] = jogada[i] & ~jogada_d[i], with jogada_d registered.
- Readout: leitura_* is a combinational mux of the stored time for sel_jog. A sel_jog value of N_JOG or more reads 0:00.
- Carga:
  - While carga=1, in any state except reset, every player loads chaves:00 each cycle.
  - fim clears, the prescaler clears and estado goes to PRONTO.
  - carga has priority over every other event in the same cycle.
- PRONTO:
  - The first press[i] with carga=0 sets ativo = (i+1) mod N_JOG, clears the prescaler and moves to CONTANDO.
  - With simultaneous presses, the lowest index wins.
  - No increment is applied on the starting press.
- CONTANDO:
  - The prescaler counts 0..CLOCK_FREQ-1. The tick is asserted for the one cycle when the count equals CLOCK_FREQ-1, and the counter wraps to 0.
  - On tick, the active player's time decrements:
    - sec>0: sec−1;
    - sec=0 and min>0: min−1, sec=59;
    - time already 0:00: no change.
  - If the time is 0:01 or 0:00 at the tick, the next state is FIM, with perdedor=ativo and fim=1 registered one cycle after the tick.
  - A valid press is press[ativo]. Presses from other players are ignored. On a valid press:
    - ativo advances to (ativo+1) mod N_JOG;
    - the prescaler clears, so the new player gets a full second;
    - if modo=1, the pressing player's time gains the clamped increment: sec+inc, and if the result is 60 or more, sec−60 with min+1.
  - Minutes saturate at 2^MIN_W−1 with seconds 59; there is no wrap.
  - Tick and valid press in the same cycle: the decrement of the outgoing player is applied first, then the increment.
  - If that decrement reaches 0:00, the flag wins: FIM, with no handover and no increment.
- FIM:
  - Times freeze, vez=0 and fim stays 1.
  - Presses are ignored. Only carga (to PRONTO) or reset leaves FIM.
- IDLE: entered only from reset; carga is the only exit.

Decomposition:
- Shared package relogio_pkg:
  - state encoding (IDLE, PRONTO, CONTANDO, FIM);
  - SEG_W=6 and SEG_MAX=59;
  - function clog2_min1.
- Sub-module gerador_tick (parameter CLOCK_FREQ):
  - inputs clock, reset, clr, en;
  - output tick, a one-cycle pulse;
  - the prescaler is cleared by clr and runs only while en=1.
- Player times are held as MIN_W+6-bit arrays indexed by player in the top module.

Test Plan:
1. CLOCK_FREQ=4, N_JOG=2, chaves=5, carga pulse → estado=PRONTO, both players read 5:00. Press jogada[1] → vez=01 (player 0 active); after 4 cycles player 0 reads 4:59, player 1 stays 5:00.
2. N_JOG=3, chaves=1. Presses by player 0 starting play, then player 1, then player 2 → vez cycles 010, 100, 001. A press by an inactive player mid-turn leaves vez and all times unchanged.
3. modo=1, incremento=10, active player at 4:55 presses → that player reads 5:05. incremento=63 → clamped to +59. MIN_W=7 at 127:50 plus 10 → saturates at 127:59.
4. chaves=0, then start → first tick gives FIM with perdedor=active index and fim=1. A chaves=1 run reaches 0:00 after 60 ticks → fim=1; later presses are ignored.
5. Tick and valid press in the same cycle with the player at 0:02 → that player reads 0:01 (+inc if modo=1) and the turn passes. Same case at 0:01 → FIM, no handover.
6. Reset asserted mid-CONTANDO (asynchronous, between clock edges) → all outputs are immediately 0 and estado=IDLE. carga during CONTANDO → reload chaves:00, estado=PRONTO, fim=0.
